// File: rtl/mem_pkg.sv
// Shared memory-port types: address/data width struct plus burst-initiator FSM encoding.
// Widths of the initiator's burst-length field default to MEM_INIT_LWIDTH_DEF.
package mem_pkg;

   typedef struct packed {
      int AWIDTH;
      int DWIDTH;
   } mem_param;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR       = 3'd1,
      ST_RD_ISSUE = 3'd2,
      ST_RD_CAPT  = 3'd3,
      ST_RD_HOLD  = 3'd4,
      ST_DONE     = 3'd5
   } mem_init_state_e;

   localparam int MEM_INIT_LWIDTH_DEF = 4;

endpackage

// File: rtl/mem_rsp_buf.sv
// Purpose: 2-entry valid/ready FIFO holding {last,data} read responses.
// Latency: one cycle from push to head visibility; no bypass inside the buffer.
// Backpressure: in_rdy drops when both entries are occupied; cnt exposes occupancy.
module mem_rsp_buf #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_dat,
   output logic [1:0]   cnt
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         push;
   logic         pop;

   assign in_rdy  = (cnt != 2'd2);
   assign out_vld = (cnt != 2'd0);
   assign out_dat = mem[rd_ptr];
   assign push    = in_vld & in_rdy;
   assign pop     = out_vld & out_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_dat;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         cnt <= cnt + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: rtl/mem_burst_initiator.sv
// Purpose: burst master for the single-port memory; option MEM_INIT_RD_PIPE_EN pipelines reads.
// Latency: writes 1 beat/cycle; reads 3 cycles/beat, or 1 beat/cycle with MEM_INIT_RD_PIPE_EN.
// Backpressure: wd_valid/rd_ready stall the burst; read data is held, never dropped.
module mem_burst_initiator
   import mem_pkg::*;
#(
   parameter mem_param P      = '{AWIDTH: 4, DWIDTH: 8},
   parameter int       LWIDTH = MEM_INIT_LWIDTH_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [P.AWIDTH-1:0] cmd_addr,
   input  logic [LWIDTH-1:0]   cmd_len,
   input  logic                wd_valid,
   output logic                wd_ready,
   input  logic [P.DWIDTH-1:0] wd_data,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic [P.DWIDTH-1:0] rd_data,
   output logic                rd_last,
   output logic [P.AWIDTH-1:0] mem_addr,
   output logic                mem_wr_en,
   output logic                mem_rd_en,
   output logic [P.DWIDTH-1:0] mem_wdata,
   input  logic [P.DWIDTH-1:0] mem_rdata,
   output logic                busy,
   output logic                done
);

   localparam int AW = P.AWIDTH;
   localparam int DW = P.DWIDTH;

   localparam logic [2:0] IDLE     = ST_IDLE;
   localparam logic [2:0] WR       = ST_WR;
   localparam logic [2:0] RD_ISSUE = ST_RD_ISSUE;
   localparam logic [2:0] RD_CAPT  = ST_RD_CAPT;
   localparam logic [2:0] RD_HOLD  = ST_RD_HOLD;
   localparam logic [2:0] DONE     = ST_DONE;

   logic [2:0]        state;
   logic [AW-1:0]     addr;
   logic [LWIDTH-1:0] len;
   logic [LWIDTH-1:0] count;
   logic              cmd_hs;

   assign cmd_ready = (state == IDLE);
   assign wd_ready  = (state == WR);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign cmd_hs    = cmd_valid & cmd_ready;

`ifdef MEM_INIT_RD_PIPE_EN
   // Occupancy counts the issue register, the beat on mem_rdata and the buffer;
   // the head beat bypasses the buffer when it is empty so one beat retires per cycle.
   logic [LWIDTH:0] iss_cnt;
   logic            mem_last_q;
   logic            pend_q;
   logic            pend_last_q;
   logic [1:0]      buf_cnt;
   logic            buf_in_rdy;
   logic            buf_out_vld;
   logic            buf_out_last;
   logic [DW-1:0]   buf_out_data;
   logic            pop;
   logic            issue;
   logic [2:0]      occ;

   always_comb begin
      pop   = rd_valid & rd_ready;
      occ   = 3'(buf_cnt) + 3'(mem_rd_en) + 3'(pend_q) - 3'(pop);
      issue = (state == RD_ISSUE) && (iss_cnt <= {1'b0, len}) && (occ < 3'd2);
   end

   assign rd_valid = buf_out_vld | pend_q;
   assign rd_data  = buf_out_vld ? buf_out_data : mem_rdata;
   assign rd_last  = buf_out_vld ? buf_out_last : pend_last_q;

   mem_rsp_buf #(.W(DW + 1)) u_rsp_buf (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (pend_q & (buf_out_vld | ~rd_ready)),
      .in_rdy  (buf_in_rdy),
      .in_dat  ({pend_last_q, mem_rdata}),
      .out_vld (buf_out_vld),
      .out_rdy (rd_ready),
      .out_dat ({buf_out_last, buf_out_data}),
      .cnt     (buf_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
      end else begin
         pend_q      <= mem_rd_en;
         pend_last_q <= mem_last_q;
      end
   end
`else
   logic [DW-1:0] rd_data_q;
   logic          rd_valid_q;
   logic          rd_last_q;

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign rd_last  = rd_last_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         addr       <= '0;
         len        <= '0;
         count      <= '0;
         mem_addr   <= '0;
         mem_wr_en  <= 1'b0;
         mem_rd_en  <= 1'b0;
         mem_wdata  <= '0;
`ifdef MEM_INIT_RD_PIPE_EN
         iss_cnt    <= '0;
         mem_last_q <= 1'b0;
`else
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
`endif
      end else begin
         mem_wr_en  <= 1'b0;
         mem_rd_en  <= 1'b0;
`ifdef MEM_INIT_RD_PIPE_EN
         mem_last_q <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (cmd_hs) begin
                  len   <= cmd_len;
                  count <= '0;
                  addr  <= cmd_addr;
                  if (cmd_write) begin
                     state <= WR;
                  end else begin
                     state <= RD_ISSUE;
`ifdef MEM_INIT_RD_PIPE_EN
                     iss_cnt <= '0;
`else
                     mem_rd_en <= 1'b1;
                     mem_addr  <= cmd_addr;
`endif
                  end
               end
            end
            WR: begin
               if (wd_valid) begin
                  mem_wr_en <= 1'b1;
                  mem_addr  <= addr;
                  mem_wdata <= wd_data;
                  addr      <= addr + 1'b1;
                  count     <= count + 1'b1;
                  if (count == len) state <= DONE;
               end
            end
`ifdef MEM_INIT_RD_PIPE_EN
            RD_ISSUE: begin
               if (issue) begin
                  mem_rd_en  <= 1'b1;
                  mem_addr   <= addr;
                  mem_last_q <= (iss_cnt == {1'b0, len});
                  addr       <= addr + 1'b1;
                  iss_cnt    <= iss_cnt + 1'b1;
               end
               if (pop) begin
                  count <= count + 1'b1;
                  if (rd_last) state <= DONE;
               end
            end
`else
            // mem_rd_en is high during RD_ISSUE, so mem_rdata is valid during RD_CAPT.
            RD_ISSUE: state <= RD_CAPT;
            RD_CAPT: begin
               rd_data_q  <= mem_rdata;
               rd_valid_q <= 1'b1;
               rd_last_q  <= (count == len);
               state      <= RD_HOLD;
            end
            RD_HOLD: begin
               if (rd_ready) begin
                  rd_valid_q <= 1'b0;
                  rd_last_q  <= 1'b0;
                  addr       <= addr + 1'b1;
                  count      <= count + 1'b1;
                  if (rd_last_q) begin
                     state <= DONE;
                  end else begin
                     mem_rd_en <= 1'b1;
                     mem_addr  <= addr + 1'b1;
                     state     <= RD_ISSUE;
                  end
               end
            end
`endif
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Bench for mem_burst_initiator with a behavioural single-port memory behind the port.
// Expected writes/reads are queued by the stimulus and checked by a negedge monitor.
module tb_mem_burst_initiator;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [3:0] cmd_addr, cmd_len;
   logic       wd_valid, wd_ready;
   logic [7:0] wd_data;
   logic       rd_valid, rd_ready, rd_last;
   logic [7:0] rd_data;
   logic [3:0] mem_addr;
   logic       mem_wr_en, mem_rd_en;
   logic [7:0] mem_wdata, mem_rdata;
   logic       busy, done;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int done_cnt = 0;
   int rd_hs_cnt = 0;
   int excl_viol = 0;

   logic [11:0] exp_wr[$];
   logic [8:0]  exp_rd[$];
   int          rd_hs_cyc[$];
   logic [7:0]  mem_arr[16];
   logic [7:0]  shadow[16];
   logic        mem_clr;
   logic [11:0] we;
   logic [8:0]  re;

`ifdef MEM_INIT_RD_PIPE_EN
   localparam int SPAN = 7;
`else
   localparam int SPAN = 21;
`endif

   mem_burst_initiator dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .wd_valid  (wd_valid),
      .wd_ready  (wd_ready),
      .wd_data   (wd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .mem_addr  (mem_addr),
      .mem_wr_en (mem_wr_en),
      .mem_rd_en (mem_rd_en),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .done      (done)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_clr) begin
         for (int i = 0; i < 16; i++) mem_arr[i] <= 8'h00;
      end else if (mem_wr_en) begin
         mem_arr[mem_addr] <= mem_wdata;
      end
      if (mem_rd_en) mem_rdata <= mem_arr[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_wr_en & mem_rd_en) excl_viol++;
         if (done) done_cnt++;
         if (mem_wr_en) begin
            if (exp_wr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wr_unexpected: got write addr=%0h data=%0h, expected none", mem_addr, mem_wdata);
            end else begin
               we = exp_wr.pop_front();
               chk("wr_addr", 32'(mem_addr), 32'(we[11:8]));
               chk("wr_data", 32'(mem_wdata), 32'(we[7:0]));
            end
         end
         if (rd_valid & rd_ready) begin
            rd_hs_cnt++;
            rd_hs_cyc.push_back(cyc);
            if (exp_rd.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rd_unexpected: got read data=%0h last=%0b, expected none", rd_data, rd_last);
            end else begin
               re = exp_rd.pop_front();
               chk("rd_data", 32'(rd_data), 32'(re[7:0]));
               chk("rd_last", 32'(rd_last), 32'(re[8]));
            end
         end
      end
   end

   task automatic send_cmd(input logic wr, input logic [3:0] a, input logic [3:0] l);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_len   = l;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int start = done_cnt;
      int n = 0;
      while (done_cnt == start && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk(name, 32'(done_cnt - start), 32'd1);
      chk({name, "_busy_low"}, 32'(busy), 32'd0);
   endtask

   task automatic write_burst(input logic [3:0] a, input logic [31:0] d);
      logic [3:0] wa;
      int n;
      for (int i = 0; i < 4; i++) begin
         wa = a + 4'(i);
         exp_wr.push_back({wa, d[31-8*i -: 8]});
         shadow[wa] = d[31-8*i -: 8];
      end
      send_cmd(1'b1, a, 4'd3);
      chk("wr_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 4; i++) begin
         wd_valid = 1'b1;
         wd_data  = d[31-8*i -: 8];
         n = 0;
         @(negedge clk);
         while (!wd_ready && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("wd_ready", 32'(wd_ready), 32'd1);
         @(posedge clk);
         #1;
      end
      wd_valid = 1'b0;
      wait_done("wr_done");
   endtask

   task automatic read_burst(input logic [3:0] a, input logic [3:0] l);
      logic [3:0] ra;
      for (int i = 0; i <= int'(l); i++) begin
         ra = a + 4'(i);
         exp_rd.push_back({(i == int'(l)), shadow[ra]});
      end
      rd_ready = 1'b1;
      send_cmd(1'b0, a, l);
      wait_done("rd_done");
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      int extra;
      int base;
      int d0;
      rst       = 1'b1;
      mem_clr   = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      wd_valid  = 1'b0;
      wd_data   = '0;
      rd_ready  = 1'b0;
      for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst     = 1'b0;
      mem_clr = 1'b0;

      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
      chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_wd_ready", 32'(wd_ready), 32'd0);

      write_burst(4'h2, 32'hA0A1A2A3);
      chk("wr_all_beats", 32'(exp_wr.size()), 32'd0);
      read_burst(4'h2, 4'd3);

      write_burst(4'hE, 32'h11223344);
      chk("wrap_all_beats", 32'(exp_wr.size()), 32'd0);
      read_burst(4'hE, 4'd3);

      // Addresses 0..7 now hold 33,44,A0,A1,A2,A3,00,00.
      rd_hs_cyc.delete();
      read_burst(4'h0, 4'd7);
      chk("thr_beats", 32'(rd_hs_cyc.size()), 32'd8);
      if (rd_hs_cyc.size() == 8) chk("thr_span", 32'(rd_hs_cyc[7] - rd_hs_cyc[0]), 32'(SPAN));

      rd_ready = 1'b0;
      exp_rd.push_back({1'b0, 8'hA0});
      exp_rd.push_back({1'b1, 8'hA1});
      send_cmd(1'b0, 4'h2, 4'd1);
      n = 0;
      @(negedge clk);
      while (!rd_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid_seen", 32'(rd_valid), 32'd1);
      extra = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(rd_valid), 32'd1);
         chk("bp_data", 32'(rd_data), 32'hA0);
         if (mem_rd_en) extra++;
      end
      chk("bp_no_extra_rd", 32'(extra), 32'd0);
      @(posedge clk);
      #1 rd_ready = 1'b1;
      wait_done("bp_done");

      rd_ready = 1'b1;
      for (int i = 0; i < 8; i++) exp_rd.push_back({(i == 7), shadow[i]});
      base = rd_hs_cnt;
      send_cmd(1'b0, 4'h0, 4'd7);
      n = 0;
      while (rd_hs_cnt < base + 1 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1 rst = 1'b1;
      d0 = done_cnt;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("mid_rst_wr_en", 32'(mem_wr_en), 32'd0);
      chk("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
      chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      exp_rd.delete();
      repeat (6) @(posedge clk);
      #1;
      chk("mid_rst_no_done", 32'(done_cnt), 32'(d0));

      read_burst(4'hE, 4'd1);

      chk("rd_all_beats", 32'(exp_rd.size()), 32'd0);
      chk("wr_rd_exclusive", 32'(excl_viol), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
